// File: rtl/ul_pkg.sv
// ul_pkg: shared definitions for the ul_seq sequential logic unit.
//   OP_*    : 2-bit operation select encodings (AND, OR, XOR, NOT A)
//   state_t : FSM state encoding for ul_seq
package ul_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/cl_n.sv
// cl_n: combinational CHUNK-wide logic slice.
//   a, b : CHUNK-bit operand slices
//   S    : operation select (OP_AND / OP_OR / OP_XOR / OP_NOTA)
//   out  : CHUNK-bit result slice (b is ignored for OP_NOTA)
module cl_n
  import ul_pkg::*;
#(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [1:0]       S,
  output logic [CHUNK-1:0] out
);

  // Bitwise operation select
  always_comb begin
    out = '0;
    case (S)
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      OP_XOR:  out = a ^ b;
      default: out = ~a;
    endcase
  end

endmodule

// File: rtl/ul_seq.sv
// ul_seq: multi-cycle bitwise logic unit; processes CHUNK bits per BUSY cycle,
// LSB slice first, using a single shared cl_n slice.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   start      : begin an operation (sampled in IDLE only)
//   A, B, S    : operands and operation select, captured on start
//   Out        : last completed result (registered)
//   busy       : high while in BUSY
//   done       : one-cycle pulse while in DONE
//   zero       : Out == 0 flag, present only when UL_ZERO_FLAG_EN is defined
module ul_seq
  import ul_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       S,
  output logic [WIDTH-1:0] Out,
  output logic             busy,
  output logic             done
`ifdef UL_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned NSLICE = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  // Reject configurations that cannot be split into whole slices
  if ((CHUNK == 0) || ((WIDTH % ((CHUNK == 0) ? 1 : CHUNK)) != 0)) begin : g_bad_cfg
    $error("ul_seq: CHUNK must be >= 1 and divide WIDTH");
  end

  state_t             state_q;
  state_t             state_n;
  logic               busy_n;
  logic               done_n;
  logic               capture;
  logic               step;
  logic               finish;
  logic               last_slice;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [1:0]         s_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   work_n;
  logic [CHUNK-1:0]   slice_a;
  logic [CHUNK-1:0]   slice_b;
  logic [CHUNK-1:0]   slice_out;
  int unsigned        shamt;

  assign last_slice = (cnt_q == CNT_W'(NSLICE - 1));

  // State register plus registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_n = state_q;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    capture = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_n = ST_BUSY;
        end
      end
      ST_BUSY: begin
        step = 1'b1;
        if (last_slice) begin
          finish  = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n == ST_BUSY);
    done_n = (state_n == ST_DONE);
  end

  // Select the current slice of the captured operands
  always_comb begin
    shamt   = 32'(cnt_q) * CHUNK;
    slice_a = CHUNK'(a_q >> shamt);
    slice_b = CHUNK'(b_q >> shamt);
  end

  cl_n #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .S   (s_q),
    .out (slice_out)
  );

  // Merge the freshly computed slice into the work register
  always_comb begin
    work_n = (work_q & ~(WIDTH'({CHUNK{1'b1}}) << shamt))
           | (WIDTH'(slice_out) << shamt);
  end

  // Operand capture, slice stepping and result load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      cnt_q  <= '0;
      work_q <= '0;
      Out    <= '0;
`ifdef UL_ZERO_FLAG_EN
      zero   <= 1'b1;
`endif
    end else if (capture) begin
      a_q    <= A;
      b_q    <= B;
      s_q    <= S;
      cnt_q  <= '0;
      work_q <= '0;
    end else if (step) begin
      work_q <= work_n;
      // Counter holds on the final slice so it never wraps mid-operation
      if (!finish) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (finish) begin
        Out  <= work_n;
`ifdef UL_ZERO_FLAG_EN
        zero <= (work_n == '0);
`endif
      end
    end
  end

endmodule
